// File: rtl/clock_timekeeper.sv
// clock_timekeeper: 1 Hz prescaler, 12-hour H:M:S counters, alarm registers,
// a button-driven set-mode FSM and an alarm ring with timeout.
//
// Handshake/event semantics: there is no valid/ready pair here. Each button
// becomes a one-cycle event pulse (synchronised level & ~previous level). An
// event is consumed on the clock edge that ends the cycle in which it is high.
// If mode and inc events coincide, the inc event is dropped.
module clock_timekeeper #(
  parameter int CLK_HZ     = 25175000,
  parameter int ALARM_SECS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  output logic [3:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [3:0] al_hour,
  output logic [5:0] al_minute,
  output logic       slow_clk,
  output logic [2:0] mode,
  output logic       alarm_ring
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PCNT_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PCNT_HALF = PW'(CLK_HZ / 2);
  localparam int RW = $clog2(ALARM_SECS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(ALARM_SECS - 1);

  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_HOUR    = 3'd1,
    SET_MIN     = 3'd2,
    SET_AL_HOUR = 3'd3,
    SET_AL_MIN  = 3'd4
  } mode_e;

  mode_e r_state;
  mode_e w_state_next;

  logic r_mode_s1, r_mode_s2, r_mode_prev;
  logic r_inc_s1, r_inc_s2, r_inc_prev;
  logic r_en_s1, r_en_s2;

  logic [PW-1:0] r_pcnt;
  logic          r_slow;
  logic [3:0]    r_hour, r_al_hour;
  logic [5:0]    r_min, r_sec, r_al_min;
  logic          r_ring;
  logic [RW-1:0] r_ring_cnt;

  logic       w_ev_mode, w_ev_inc, w_inc, w_en, w_tick, w_time_run;
  logic       w_sec_wrap, w_min_wrap;
  logic [5:0] w_sec_adv, w_min_adv, w_min_inc, w_al_min_inc;
  logic [3:0] w_hr_adv, w_hr_inc, w_al_hr_inc;
  logic       w_alarm_set, w_alarm_clr;

  assign w_ev_mode = r_mode_s2 & ~r_mode_prev;
  assign w_ev_inc  = r_inc_s2 & ~r_inc_prev;
  assign w_inc     = w_ev_inc & ~w_ev_mode;
  assign w_en      = r_en_s2;
  assign w_tick    = (r_pcnt == PCNT_MAX);
  // Time is frozen only while the user edits hour or minute.
  assign w_time_run = (r_state == RUN) || (r_state == SET_AL_HOUR) || (r_state == SET_AL_MIN);

  // Two-flop synchronisers for all async inputs, third flop for button edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_s1   <= 1'b0;
      r_mode_s2   <= 1'b0;
      r_mode_prev <= 1'b0;
      r_inc_s1    <= 1'b0;
      r_inc_s2    <= 1'b0;
      r_inc_prev  <= 1'b0;
      r_en_s1     <= 1'b0;
      r_en_s2     <= 1'b0;
    end else begin
      r_mode_s1   <= btn_mode;
      r_mode_s2   <= r_mode_s1;
      r_mode_prev <= r_mode_s2;
      r_inc_s1    <= btn_inc;
      r_inc_s2    <= r_inc_s1;
      r_inc_prev  <= r_inc_s2;
      r_en_s1     <= alarm_en;
      r_en_s2     <= r_en_s1;
    end
  end

  // Free-running prescaler and registered 1 Hz square wave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_slow <= 1'b0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
      r_slow <= (r_pcnt < PCNT_HALF);
    end
  end

  // Next-value arithmetic for the running clock and the edit increments
  always_comb begin
    w_sec_wrap   = (r_sec == 6'd59);
    w_min_wrap   = (r_min == 6'd59);
    w_sec_adv    = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    w_min_adv    = r_min;
    w_hr_adv     = r_hour;
    if (w_sec_wrap) begin
      w_min_adv = w_min_wrap ? 6'd0 : r_min + 6'd1;
      if (w_min_wrap) begin
        w_hr_adv = (r_hour == 4'd11) ? 4'd0 : r_hour + 4'd1;
      end
    end
    w_hr_inc     = (r_hour == 4'd11) ? 4'd0 : r_hour + 4'd1;
    w_min_inc    = w_min_wrap ? 6'd0 : r_min + 6'd1;
    w_al_hr_inc  = (r_al_hour == 4'd11) ? 4'd0 : r_al_hour + 4'd1;
    w_al_min_inc = (r_al_min == 6'd50) ? 6'd0 : r_al_min + 6'd10;
  end

  // Running time: tick advance, second clear on entering set mode, edits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
    end else begin
      if (w_time_run && w_tick) begin
        r_sec  <= w_sec_adv;
        r_min  <= w_min_adv;
        r_hour <= w_hr_adv;
      end
      if ((r_state == RUN) && w_ev_mode) r_sec <= '0;
      if (w_inc && (r_state == SET_HOUR)) r_hour <= w_hr_inc;
      if (w_inc && (r_state == SET_MIN)) r_min <= w_min_inc;
    end
  end

  // Alarm time registers, edited in the alarm set modes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_al_hour <= '0;
      r_al_min  <= '0;
    end else begin
      if (w_inc && (r_state == SET_AL_HOUR)) r_al_hour <= w_al_hr_inc;
      if (w_inc && (r_state == SET_AL_MIN)) r_al_min <= w_al_min_inc;
    end
  end

  // The match uses the post-tick values, so the ring starts with the H:M:00 display.
  assign w_alarm_set = (r_state == RUN) && w_tick && (w_sec_adv == 6'd0) &&
                       (w_min_adv == r_al_min) && (w_hr_adv == r_al_hour) && w_en;
  assign w_alarm_clr = (w_inc && (r_state == RUN)) || !w_en ||
                       (r_ring && w_tick && (r_ring_cnt == RING_LAST));

  // Alarm ring flag and its timeout counter; set has priority over clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring     <= 1'b0;
      r_ring_cnt <= '0;
    end else if (w_alarm_set) begin
      r_ring     <= 1'b1;
      r_ring_cnt <= '0;
    end else begin
      if (r_ring && w_tick) r_ring_cnt <= r_ring_cnt + RW'(1);
      if (w_alarm_clr) r_ring <= 1'b0;
    end
  end

  // Mode FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  // Mode FSM next state: cycle through edit modes on each mode event
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:         if (w_ev_mode) w_state_next = SET_HOUR;
      SET_HOUR:    if (w_ev_mode) w_state_next = SET_MIN;
      SET_MIN:     if (w_ev_mode) w_state_next = SET_AL_HOUR;
      SET_AL_HOUR: if (w_ev_mode) w_state_next = SET_AL_MIN;
      SET_AL_MIN:  if (w_ev_mode) w_state_next = RUN;
      default:     w_state_next = RUN;
    endcase
  end

  assign hour       = r_hour;
  assign minute     = r_min;
  assign second     = r_sec;
  assign al_hour    = r_al_hour;
  assign al_minute  = r_al_min;
  assign slow_clk   = r_slow;
  assign mode       = r_state;
  assign alarm_ring = r_ring;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper with CLK_HZ=4, ALARM_SECS=3.
module tb_clock_timekeeper;

  localparam int CLK_HZ     = 4;
  localparam int ALARM_SECS = 3;
  localparam int DAY        = 12 * 3600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic [3:0] hour, al_hour;
  logic [5:0] minute, second, al_minute;
  logic       slow_clk, alarm_ring;
  logic [2:0] mode;

  int checks = 0;
  int errors = 0;

  clock_timekeeper #(.CLK_HZ(CLK_HZ), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .alarm_en(alarm_en), .hour(hour), .minute(minute), .second(second),
    .al_hour(al_hour), .al_minute(al_minute), .slow_clk(slow_clk),
    .mode(mode), .alarm_ring(alarm_ring)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Time kept as seconds since 0:00:00 on a 12-hour dial; button events derived
  // from the per-edge history of pin samples (two samples of synchroniser delay).
  int       m_t, m_alh, m_alm, m_mode, m_rcnt, m_edges, m_tick_cnt;
  bit       m_ring, m_slow;
  bit [2:0] hm, hi, he;
  bit       mv_evm, mv_evi, mv_en, mv_tk, mv_inc, mv_set, mv_clr;
  int       mv_adv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_alh = 0; m_alm = 0; m_mode = 0; m_rcnt = 0; m_edges = 0;
      m_ring = 0; m_slow = 0; hm = 0; hi = 0; he = 0;
    end else begin
      mv_evm = hm[1] & ~hm[2];
      mv_evi = hi[1] & ~hi[2];
      mv_en  = he[1];
      mv_tk  = (m_edges % CLK_HZ) == CLK_HZ - 1;
      m_slow = (m_edges % CLK_HZ) < CLK_HZ / 2;
      mv_inc = mv_evi & ~mv_evm;
      mv_adv = m_t;
      if (mv_tk && (m_mode == 0 || m_mode >= 3)) mv_adv = (m_t + 1) % DAY;
      mv_set = (m_mode == 0) && mv_tk && (mv_adv % 60 == 0) &&
               (mv_adv / 60 == m_alh * 60 + m_alm) && mv_en;
      mv_clr = (mv_inc && m_mode == 0) || !mv_en ||
               (m_ring && mv_tk && m_rcnt == ALARM_SECS - 1);
      if (mv_set) begin
        m_ring = 1; m_rcnt = 0;
      end else begin
        if (m_ring && mv_tk) m_rcnt++;
        if (mv_clr) m_ring = 0;
      end
      if (m_mode == 0 && mv_evm) mv_adv = mv_adv - mv_adv % 60;
      if (mv_inc) begin
        case (m_mode)
          1: mv_adv = ((mv_adv / 3600 + 1) % 12) * 3600 + mv_adv % 3600;
          2: mv_adv = (mv_adv / 3600) * 3600 + (((mv_adv / 60) % 60 + 1) % 60) * 60 + mv_adv % 60;
          3: m_alh = (m_alh + 1) % 12;
          4: m_alm = (m_alm + 10) % 60;
          default: ;
        endcase
      end
      m_t = mv_adv;
      if (mv_evm) m_mode = (m_mode + 1) % 5;
      if (mv_tk) m_tick_cnt++;
      m_edges++;
      hm = {hm[1:0], btn_mode};
      hi = {hi[1:0], btn_inc};
      he = {he[1:0], alarm_en};
    end
  end

  // ---------------- scoreboard ----------------
  logic [30:0] exp_q[$];
  logic [30:0] sb_act, sb_exp;
  bit          chk_on = 0;

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      exp_q.push_back({4'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 4'(m_alh),
                       6'(m_alm), m_slow, 3'(m_mode), m_ring});
      sb_exp = exp_q.pop_front();
      sb_act = {hour, minute, second, al_hour, al_minute, slow_clk, mode, alarm_ring};
      checks++;
      if (sb_act !== sb_exp) begin
        errors++;
        $display("FAIL model @%0t: got %h expected %h", $time, sb_act, sb_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic press(input bit pm, input bit pi);
    @(negedge clk);
    btn_mode = pm;
    btn_inc  = pi;
    repeat (4) @(negedge clk);
    btn_mode = 0;
    btn_inc  = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int budget;
    target = m_tick_cnt + n;
    budget = n * CLK_HZ + 8;
    while (m_tick_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (m_tick_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_ticks: got %0d ticks expected %0d", m_tick_cnt, target);
    end
  endtask

  task automatic wait_time(input int target);
    int budget;
    budget = 70 * CLK_HZ;
    while (m_t != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (m_t != target) begin
      checks++; errors++;
      $display("FAIL wait_time: got %0d expected %0d", m_t, target);
    end
  endtask

  // From RUN: walk through every set mode, landing on h:m and alarm ah:am.
  task automatic set_time(input int h, input int m, input int ah, input int am);
    press(1, 0);
    repeat ((h - m_t / 3600 + 12) % 12) press(0, 1);
    press(1, 0);
    repeat ((m - (m_t / 60) % 60 + 60) % 60) press(0, 1);
    press(1, 0);
    repeat ((ah - m_alh + 12) % 12) press(0, 1);
    press(1, 0);
    repeat (((am - m_alm) / 10 + 6) % 6) press(0, 1);
    press(1, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         do_mode;
    bit         do_inc;
    logic [2:0] exp_mode;
    logic [3:0] exp_alh;
    logic [5:0] exp_alm;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit dm, bit di, int em, int eh, int emin);
    vec_t v;
    v.do_mode = dm; v.do_inc = di;
    v.exp_mode = 3'(em); v.exp_alh = 4'(eh); v.exp_alm = 6'(emin);
    return v;
  endfunction

  initial begin
    // alarm-setting wrap table starting from reset state
    vecs.push_back(mk(1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 3, 0, 0));
    for (int i = 1; i <= 12; i++) vecs.push_back(mk(0, 1, 3, i % 12, 0));
    vecs.push_back(mk(1, 0, 4, 0, 0));
    for (int i = 1; i <= 6; i++) vecs.push_back(mk(0, 1, 4, 0, (10 * i) % 60));
    vecs.push_back(mk(1, 0, 0, 0, 0));

    // reset, then 50 busy cycles, then asynchronous reset between edges
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk_on = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      btn_mode = 1'($urandom_range(0, 1));
      btn_inc  = 1'($urandom_range(0, 1));
      alarm_en = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_hour", hour, 0);
    chk("rst_minute", minute, 0);
    chk("rst_second", second, 0);
    chk("rst_al_hour", al_hour, 0);
    chk("rst_al_minute", al_minute, 0);
    chk("rst_slow_clk", slow_clk, 0);
    chk("rst_mode", mode, 0);
    chk("rst_alarm_ring", alarm_ring, 0);
    btn_mode = 0; btn_inc = 0; alarm_en = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // prescaler: tick every 4 edges, slow_clk 1,1,0,0
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk("pre_second", second, n / CLK_HZ);
      chk("pre_slow_clk", slow_clk, ((n - 1) % CLK_HZ) < CLK_HZ / 2);
    end

    // alarm setting wrap table
    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].do_mode, vecs[i].do_inc);
      chk("tbl_mode", mode, vecs[i].exp_mode);
      chk("tbl_al_hour", al_hour, vecs[i].exp_alh);
      chk("tbl_al_minute", al_minute, vecs[i].exp_alm);
    end

    // rollover 11:59:59 -> 0:00:00 in one tick
    set_time(11, 59, 0, 0);
    chk("roll_mode", mode, 0);
    wait_time(11 * 3600 + 59 * 60 + 59);
    chk("roll_pre_hour", hour, 11);
    chk("roll_pre_minute", minute, 59);
    chk("roll_pre_second", second, 59);
    wait_ticks(1);
    chk("roll_hour", hour, 0);
    chk("roll_minute", minute, 0);
    chk("roll_second", second, 0);

    // alarm rings at 1:10:00 and times out after 3 ticks
    set_time(1, 9, 1, 10);
    alarm_en = 1;
    chk("al_set_hour", al_hour, 1);
    chk("al_set_minute", al_minute, 10);
    wait_time(1 * 3600 + 9 * 60 + 59);
    chk("ring_before", alarm_ring, 0);
    wait_ticks(1);
    chk("ring_hour", hour, 1);
    chk("ring_minute", minute, 10);
    chk("ring_second", second, 0);
    chk("ring_rise", alarm_ring, 1);
    wait_ticks(2);
    chk("ring_hold", alarm_ring, 1);
    wait_ticks(1);
    chk("ring_timeout", alarm_ring, 0);

    // alarm cleared by inc press after one tick
    set_time(1, 9, 1, 10);
    wait_time(1 * 3600 + 9 * 60 + 59);
    wait_ticks(1);
    chk("ring2_rise", alarm_ring, 1);
    wait_ticks(1);
    btn_inc = 1;
    repeat (2) @(negedge clk);
    chk("ring2_hold", alarm_ring, 1);
    @(negedge clk);
    chk("ring2_clear", alarm_ring, 0);
    btn_inc = 0;
    repeat (4) @(negedge clk);

    // alarm disabled never rings
    alarm_en = 0;
    set_time(1, 9, 1, 10);
    wait_time(1 * 3600 + 9 * 60 + 59);
    wait_ticks(1);
    chk("noring_minute", minute, 10);
    chk("noring_rise", alarm_ring, 0);
    wait_ticks(3);
    chk("noring_later", alarm_ring, 0);

    // mode and inc events collide in SET_HOUR: inc dropped
    press(1, 0);
    repeat ((5 - m_t / 3600 + 12) % 12) press(0, 1);
    chk("coll_pre_hour", hour, 5);
    press(1, 1);
    chk("coll_mode", mode, 2);
    chk("coll_hour", hour, 5);
    repeat (3) press(1, 0);
    chk("coll_back_run", mode, 0);

    // randomized traffic against the model
    alarm_en = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 5) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
    end

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
